// File: rtl/counter_pkg.sv
// counter_pkg: shared mode and direction types for step counters
package counter_pkg;
  typedef enum logic {COUNT_WRAP, COUNT_SATURATE} count_mode_e;
  typedef enum logic {DIR_UP, DIR_DOWN} count_dir_e;
endpackage

// File: rtl/step_calc.sv
// step_calc: combinational successor of count for one step in either direction
module step_calc import counter_pkg::*; #(
  parameter int unsigned MAX_VALUE = 255,
  parameter int unsigned STEP = 1,
  parameter count_mode_e MODE = COUNT_WRAP,
  localparam int unsigned W = $clog2(MAX_VALUE + 1)
) (
  input  logic [W-1:0] count,
  input  count_dir_e   direction,
  output logic [W-1:0] next_count,
  output logic         limit_hit
);
  localparam logic [W-1:0] MAX_W = W'(MAX_VALUE);
  localparam logic [W-1:0] STEP_W = W'(STEP);
  localparam logic [W-1:0] HEADROOM = W'(MAX_VALUE - STEP);
  logic up;
  logic sat;
  always_comb begin
    up = direction == DIR_UP;
    sat = MODE == COUNT_SATURATE;
    limit_hit = up ? count > HEADROOM : count < STEP_W;
    next_count = up ? count + STEP_W : count - STEP_W;
    if (limit_hit) next_count = (up ^ sat) ? '0 : MAX_W;
  end
endmodule

// File: rtl/step_counter.sv
// step_counter: registered wrap/saturate step counter with load, clear and terminal pulse
module step_counter import counter_pkg::*; #(
  parameter int unsigned MAX_VALUE = 255,
  parameter int unsigned STEP = 1,
  parameter count_mode_e MODE = COUNT_WRAP,
  localparam int unsigned W = $clog2(MAX_VALUE + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  input  count_dir_e   direction,
  output logic [W-1:0] count,
  output logic         terminal,
  output logic         at_max,
  output logic         at_min
);
  localparam logic [W-1:0] MAX_W = W'(MAX_VALUE);
  if (MAX_VALUE < 1) begin : g_bad_max
    $error("step_counter: MAX_VALUE must be at least 1");
  end
  if (STEP < 1 || STEP > MAX_VALUE) begin : g_bad_step
    $error("step_counter: STEP must be in 1..MAX_VALUE");
  end
  logic [W-1:0] step_next;
  logic         step_limit;
  logic [W-1:0] load_clamped;
  step_calc #(.MAX_VALUE(MAX_VALUE), .STEP(STEP), .MODE(MODE)) u_step_calc (
    .count(count),
    .direction(direction),
    .next_count(step_next),
    .limit_hit(step_limit)
  );
  assign load_clamped = load_value > MAX_W ? MAX_W : load_value;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      terminal <= 1'b0;
    end else begin
      count <= clear ? '0 : load ? load_clamped : enable ? step_next : count;
      terminal <= !clear && !load && enable && step_limit;
    end
  end
  assign at_max = count == MAX_W;
  assign at_min = count == '0;
endmodule

// File: tb/tb_step_counter.sv
// tb_step_counter: four differently parametrised counters checked against directed sequences and an integer model
module tb_step_counter;
  import counter_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_n, clear, load, enable;
  logic [7:0] lv;
  count_dir_e dir;
  logic [3:0] cnt_a;
  logic [7:0] cnt_b;
  logic [6:0] cnt_c;
  logic [2:0] cnt_d;
  logic term_a, term_b, term_c, term_d;
  logic mx_a, mx_b, mx_c, mx_d, mn_a, mn_b, mn_c, mn_d;
  step_counter #(.MAX_VALUE(9), .STEP(3), .MODE(COUNT_WRAP)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_value(lv[3:0]),
    .enable(enable), .direction(dir), .count(cnt_a), .terminal(term_a), .at_max(mx_a), .at_min(mn_a));
  step_counter #(.MAX_VALUE(255), .STEP(16), .MODE(COUNT_SATURATE)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_value(lv),
    .enable(enable), .direction(dir), .count(cnt_b), .terminal(term_b), .at_max(mx_b), .at_min(mn_b));
  step_counter #(.MAX_VALUE(100), .STEP(7), .MODE(COUNT_SATURATE)) u_c (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_value(lv[6:0]),
    .enable(enable), .direction(dir), .count(cnt_c), .terminal(term_c), .at_max(mx_c), .at_min(mn_c));
  step_counter #(.MAX_VALUE(7), .STEP(7), .MODE(COUNT_WRAP)) u_d (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_value(lv[2:0]),
    .enable(enable), .direction(dir), .count(cnt_d), .terminal(term_d), .at_max(mx_d), .at_min(mn_d));
  logic [31:0] dut_cnt [4];
  logic        dut_term [4], dut_max [4], dut_min [4];
  always_comb begin
    dut_cnt[0] = 32'(cnt_a);
    dut_cnt[1] = 32'(cnt_b);
    dut_cnt[2] = 32'(cnt_c);
    dut_cnt[3] = 32'(cnt_d);
    dut_term = '{term_a, term_b, term_c, term_d};
    dut_max = '{mx_a, mx_b, mx_c, mx_d};
    dut_min = '{mn_a, mn_b, mn_c, mn_d};
  end
  int p_max [4] = '{9, 255, 100, 7};
  int p_step [4] = '{3, 16, 7, 7};
  int p_w [4] = '{4, 8, 7, 3};
  bit p_sat [4] = '{0, 1, 1, 0};
  int mcnt [4] = '{0, 0, 0, 0};
  bit mterm [4] = '{0, 0, 0, 0};
  int n_cmp = 0;
  int n_bad = 0;
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      int lvt;
      int nxt;
      lvt = int'(lv) % (1 << p_w[i]);
      mterm[i] = 0;
      if (!rst_n || clear) mcnt[i] = 0;
      else if (load) mcnt[i] = lvt > p_max[i] ? p_max[i] : lvt;
      else if (enable) begin
        nxt = dir == DIR_UP ? mcnt[i] + p_step[i] : mcnt[i] - p_step[i];
        if (nxt > p_max[i] || nxt < 0) begin
          mterm[i] = 1;
          if (dir == DIR_UP) mcnt[i] = p_sat[i] ? p_max[i] : 0;
          else mcnt[i] = p_sat[i] ? 0 : p_max[i];
        end else mcnt[i] = nxt;
      end
    end
    #1;
  endtask
  task automatic idle();
    clear = 0; load = 0; enable = 0; dir = DIR_UP; lv = 0;
  endtask
  task automatic test_reset();
    idle();
    rst_n = 0; enable = 1; load = 1; lv = 8'd5;
    repeat (2) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (dut_cnt[i] !== 0 || dut_term[i] !== 1'b0 || dut_min[i] !== 1'b1 || dut_max[i] !== 1'b0) begin
          n_bad++;
          $display("FAIL reset[%0d]: count=%0d terminal=%b at_min=%b at_max=%b, expected 0/0/1/0",
                   i, dut_cnt[i], dut_term[i], dut_min[i], dut_max[i]);
        end
      end
    end
    rst_n = 1; load = 0;
    tick();
    n_cmp++;
    if (dut_cnt[0] !== 3) begin
      n_bad++;
      $display("FAIL reset_release: count=%0d expected 3", dut_cnt[0]);
    end
  endtask
  task automatic test_wrap_up();
    int exp_c [5] = '{3, 6, 9, 0, 3};
    bit exp_t [5] = '{0, 0, 0, 1, 0};
    idle(); clear = 1; tick();
    clear = 0; enable = 1; dir = DIR_UP;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (dut_cnt[0] !== exp_c[k] || dut_term[0] !== exp_t[k]) begin
        n_bad++;
        $display("FAIL wrap_up[%0d]: count=%0d terminal=%b expected %0d/%b", k, dut_cnt[0], dut_term[0], exp_c[k], exp_t[k]);
      end
    end
  endtask
  task automatic test_wrap_down();
    int exp_c [3] = '{1, 9, 6};
    bit exp_t [3] = '{0, 1, 0};
    idle(); load = 1; lv = 8'd4; tick();
    load = 0; enable = 1; dir = DIR_DOWN;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (dut_cnt[0] !== exp_c[k] || dut_term[0] !== exp_t[k]) begin
        n_bad++;
        $display("FAIL wrap_down[%0d]: count=%0d terminal=%b expected %0d/%b", k, dut_cnt[0], dut_term[0], exp_c[k], exp_t[k]);
      end
    end
  endtask
  task automatic test_saturate();
    idle(); load = 1; lv = 8'd250; tick();
    load = 0; enable = 1; dir = DIR_UP;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (dut_cnt[1] !== 255 || dut_term[1] !== 1'b1 || dut_max[1] !== 1'b1) begin
        n_bad++;
        $display("FAIL saturate[%0d]: count=%0d terminal=%b at_max=%b expected 255/1/1", k, dut_cnt[1], dut_term[1], dut_max[1]);
      end
    end
    dir = DIR_DOWN;
    tick();
    n_cmp++;
    if (dut_cnt[1] !== 239 || dut_term[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL saturate_down: count=%0d terminal=%b expected 239/0", dut_cnt[1], dut_term[1]);
    end
  endtask
  task automatic test_priority();
    idle(); clear = 1; load = 1; enable = 1; lv = 8'd50; tick();
    n_cmp++;
    if (dut_cnt[2] !== 0 || dut_term[2] !== 1'b0 || dut_min[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL prio_clear: count=%0d terminal=%b at_min=%b expected 0/0/1", dut_cnt[2], dut_term[2], dut_min[2]);
    end
    clear = 0; lv = 8'd120; tick();
    n_cmp++;
    if (dut_cnt[2] !== 100 || dut_max[2] !== 1'b1 || dut_term[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_clamp: count=%0d at_max=%b terminal=%b expected 100/1/0", dut_cnt[2], dut_max[2], dut_term[2]);
    end
    load = 0; tick();
    n_cmp++;
    if (dut_cnt[2] !== 100 || dut_term[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_at_limit: count=%0d terminal=%b expected 100/1", dut_cnt[2], dut_term[2]);
    end
  endtask
  task automatic test_step_max();
    int exp_c [3] = '{7, 0, 7};
    bit exp_t [3] = '{0, 1, 0};
    idle(); clear = 1; tick();
    clear = 0; enable = 1; dir = DIR_UP;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (dut_cnt[3] !== exp_c[k] || dut_term[3] !== exp_t[k]) begin
        n_bad++;
        $display("FAIL step_max[%0d]: count=%0d terminal=%b expected %0d/%b", k, dut_cnt[3], dut_term[3], exp_c[k], exp_t[k]);
      end
    end
  endtask
  task automatic test_reset_mid();
    idle(); load = 1; lv = 8'd250; tick();
    load = 0; enable = 1; tick();
    rst_n = 0; tick();
    n_cmp++;
    if (dut_cnt[1] !== 0 || dut_term[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: count=%0d terminal=%b expected 0/0", dut_cnt[1], dut_term[1]);
    end
    rst_n = 1; enable = 0; tick();
    n_cmp++;
    if (dut_cnt[1] !== 0 || dut_term[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL hold: count=%0d terminal=%b expected 0/0", dut_cnt[1], dut_term[1]);
    end
  endtask
  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rst_n = $urandom_range(0, 49) != 0;
      clear = $urandom_range(0, 19) == 0;
      load = $urandom_range(0, 9) == 0;
      enable = $urandom_range(0, 9) < 7;
      dir = count_dir_e'($urandom_range(0, 1));
      lv = 8'($urandom);
      tick();
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (dut_cnt[i] !== mcnt[i] || dut_term[i] !== mterm[i] ||
            dut_max[i] !== (mcnt[i] == p_max[i]) || dut_min[i] !== (mcnt[i] == 0)) begin
          n_bad++;
          $display("FAIL random[%0d] dut%0d: count=%0d terminal=%b at_max=%b at_min=%b expected count=%0d terminal=%b",
                   k, i, dut_cnt[i], dut_term[i], dut_max[i], dut_min[i], mcnt[i], mterm[i]);
        end
      end
    end
  endtask
  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_priority();
    test_step_max();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
